// File: rtl/rot_pkg.sv
// Shared constants, widths and parser state encoding for the dial pipeline front end.
package rot_pkg;

  localparam int unsigned DIST_W = 16;
  localparam int unsigned CNT_W  = 16;

  localparam logic [7:0] ASCII_L  = 8'h4C;
  localparam logic [7:0] ASCII_R  = 8'h52;
  localparam logic [7:0] ASCII_0  = 8'h30;
  localparam logic [7:0] ASCII_9  = 8'h39;
  localparam logic [7:0] ASCII_LF = 8'h0A;
  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_SP = 8'h20;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIGITS = 2'd1,
    EMIT   = 2'd2,
    SKIP   = 2'd3
  } parse_state_t;

  function automatic logic is_digit(input logic [7:0] b);
    return (b >= ASCII_0) && (b <= ASCII_9);
  endfunction

endpackage

// File: rtl/rotation_parser_if.sv
// Byte-in / command-out bundle between the text source, the parser and the dial stage.
interface rotation_parser_if #(
  parameter int unsigned DIST_W = rot_pkg::DIST_W,
  parameter int unsigned CNT_W  = rot_pkg::CNT_W
) ();

  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              valid;
  logic              direction;
  logic [DIST_W-1:0] distance;
  logic              ready;
  logic [CNT_W-1:0]  cmd_count;
  logic              err;

  modport master (
    input  in_valid, in_data, ready,
    output in_ready, valid, direction, distance, cmd_count, err
  );

  modport slave (
    output in_valid, in_data, ready,
    input  in_ready, valid, direction, distance, cmd_count, err
  );

endinterface

// File: rtl/rot_dec_acc.sv
// Saturating decimal accumulator: acc <- acc*10 + digit, pinned at all-ones once it overflows.
module rot_dec_acc #(
  parameter int unsigned DIST_W = rot_pkg::DIST_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              dig_en,
  input  logic [3:0]        digit,
  output logic [DIST_W-1:0] acc,
  output logic              seen
);

  localparam int unsigned WIDE_W = DIST_W + 4;
  localparam logic [WIDE_W-1:0] MAX_WIDE = WIDE_W'({DIST_W{1'b1}});

  logic [WIDE_W-1:0] wide;

  // max*10+9 still fits in WIDE_W, so a saturated value stays saturated
  always_comb wide = WIDE_W'(acc) * WIDE_W'(10) + WIDE_W'(digit);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc  <= '0;
      seen <= 1'b0;
    end else if (clr) begin
      acc  <= '0;
      seen <= 1'b0;
    end else if (dig_en) begin
      acc  <= (wide > MAX_WIDE) ? '1 : DIST_W'(wide);
      seen <= 1'b1;
    end
  end

endmodule

// File: rtl/rotation_parser.sv
// ASCII rotation lines ("L68\n") to direction/distance commands over valid/ready.
// Define ROT_PARSER_ERR_EN to flag malformed lines on err and skip to the next LF.
module rotation_parser #(
  parameter int unsigned DIST_W = rot_pkg::DIST_W,
  parameter int unsigned CNT_W  = rot_pkg::CNT_W
) (
  input logic              clk,
  input logic              rst_n,
  rotation_parser_if.master bus
);

  import rot_pkg::*;

  localparam logic [1:0] S_IDLE   = 2'(IDLE);
  localparam logic [1:0] S_DIGITS = 2'(DIGITS);
  localparam logic [1:0] S_EMIT   = 2'(EMIT);
`ifdef ROT_PARSER_ERR_EN
  localparam logic [1:0] S_SKIP   = 2'(SKIP);
`endif

  logic [1:0]        state, state_n;
  logic              in_ready_q, valid_q;
  logic              dir_q, dir_n;
  logic [DIST_W-1:0] dist_q, dist_n;
  logic [CNT_W-1:0]  cnt_q, cnt_n;
  logic              acc_clr, dig_en, seen, take;
  logic [DIST_W-1:0] acc;
  logic [7:0]        b;
`ifdef ROT_PARSER_ERR_EN
  logic              err_q, err_n;
`endif

  assign b    = bus.in_data;
  assign take = bus.in_valid && in_ready_q;

  rot_dec_acc #(.DIST_W(DIST_W)) u_acc (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (acc_clr),
    .dig_en (dig_en),
    .digit  (4'(b - ASCII_0)),
    .acc    (acc),
    .seen   (seen)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      in_ready_q <= 1'b1;
      valid_q    <= 1'b0;
      dir_q      <= 1'b0;
      dist_q     <= '0;
      cnt_q      <= '0;
`ifdef ROT_PARSER_ERR_EN
      err_q      <= 1'b0;
`endif
    end else begin
      state      <= state_n;
      in_ready_q <= (state_n != S_EMIT);
      valid_q    <= (state_n == S_EMIT);
      dir_q      <= dir_n;
      dist_q     <= dist_n;
      cnt_q      <= cnt_n;
`ifdef ROT_PARSER_ERR_EN
      err_q      <= err_n;
`endif
    end
  end

  always_comb begin
    state_n = state;
    dir_n   = dir_q;
    dist_n  = dist_q;
    cnt_n   = cnt_q;
    acc_clr = 1'b0;
    dig_en  = 1'b0;
`ifdef ROT_PARSER_ERR_EN
    err_n   = err_q;
`endif
    case (state)
      S_IDLE: begin
        if (take) begin
          if (b == ASCII_L || b == ASCII_R) begin
            dir_n   = (b == ASCII_R);
            acc_clr = 1'b1;
            state_n = S_DIGITS;
          end else if (b == ASCII_LF || b == ASCII_CR || b == ASCII_SP) begin
            state_n = S_IDLE;
          end else begin
`ifdef ROT_PARSER_ERR_EN
            err_n   = 1'b1;
            state_n = S_SKIP;
`endif
          end
        end
      end
      S_DIGITS: begin
        if (take) begin
          if (is_digit(b)) begin
            dig_en = 1'b1;
          end else if (b == ASCII_CR) begin
            state_n = S_DIGITS;
          end else if (b == ASCII_LF) begin
            // a digitless line returns to IDLE without a command
            if (seen) begin
              dist_n  = acc;
              state_n = S_EMIT;
            end else begin
              state_n = S_IDLE;
`ifdef ROT_PARSER_ERR_EN
              err_n   = 1'b1;
`endif
            end
          end else begin
`ifdef ROT_PARSER_ERR_EN
            err_n   = 1'b1;
            state_n = S_SKIP;
`endif
          end
        end
      end
      S_EMIT: begin
        if (bus.ready) begin
          cnt_n   = cnt_q + CNT_W'(1);
          state_n = S_IDLE;
        end
      end
`ifdef ROT_PARSER_ERR_EN
      S_SKIP: begin
        if (take && b == ASCII_LF) state_n = S_IDLE;
      end
`endif
      default: state_n = S_IDLE;
    endcase
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.valid     = valid_q;
  assign bus.direction = dir_q;
  assign bus.distance  = dist_q;
  assign bus.cmd_count = cnt_q;
`ifdef ROT_PARSER_ERR_EN
  assign bus.err       = err_q;
`else
  assign bus.err       = 1'b0;
`endif

endmodule

// File: tb/tb_rotation_parser.sv
// Directed plus random byte streams against a line-level model of the rotation parser.
module tb_rotation_parser;

  localparam int unsigned DW = 16;
  localparam int unsigned CW = 16;
  localparam logic [7:0] C_LF = 8'h0A;
  localparam logic [7:0] C_CR = 8'h0D;
  localparam logic [7:0] C_SP = 8'h20;
  localparam logic [7:0] C_L  = 8'h4C;
  localparam logic [7:0] C_R  = 8'h52;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;

  rotation_parser_if #(.DIST_W(DW), .CNT_W(CW)) bus ();

  rotation_parser #(.DIST_W(DW), .CNT_W(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  int            n_cmp  = 0;
  int            n_fail = 0;
  logic [DW:0]   exp_q[$];
  logic [CW-1:0] exp_count = '0;
  logic          exp_err   = 1'b0;
  string         pend      = "";
  logic          pending   = 1'b0;
  logic [DW:0]   held      = '0;
  int            lf_cyc    = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic bit is_dig(input byte c);
    return (c >= 8'h30) && (c <= 8'h39);
  endfunction

  // Reference: evaluate a whole line (without its LF) by the text rules.
  function automatic void model_line(input string ln);
    int     p = 0;
    longint acc = 0;
    bit     seen = 0;
    bit     dir;
`ifdef ROT_PARSER_ERR_EN
    while (p < ln.len() && (ln[p] == C_CR || ln[p] == C_SP)) p++;
    if (p == ln.len()) return;
    if (ln[p] != C_L && ln[p] != C_R) begin exp_err = 1'b1; return; end
    dir = (ln[p] == C_R);
    for (int i = p + 1; i < ln.len(); i++) begin
      if (is_dig(ln[i])) begin
        acc = acc * 10 + longint'(ln[i] - 8'h30);
        if (acc > 65535) acc = 65535;
        seen = 1;
      end else if (ln[i] != C_CR) begin
        exp_err = 1'b1;
        return;
      end
    end
    if (!seen) begin exp_err = 1'b1; return; end
`else
    while (p < ln.len() && ln[p] != C_L && ln[p] != C_R) p++;
    if (p == ln.len()) return;
    dir = (ln[p] == C_R);
    for (int i = p + 1; i < ln.len(); i++) begin
      if (is_dig(ln[i])) begin
        acc = acc * 10 + longint'(ln[i] - 8'h30);
        if (acc > 65535) acc = 65535;
        seen = 1;
      end
    end
    if (!seen) return;
`endif
    exp_q.push_back({dir, 16'(acc)});
  endfunction

  function automatic void model_feed(input string s);
    for (int i = 0; i < s.len(); i++) begin
      if (s[i] == C_LF) begin
        model_line(pend);
        pend = "";
      end else begin
        pend = $sformatf("%s%c", pend, s[i]);
      end
    end
  endfunction

  function automatic string rand_line();
    string s = "";
    string alpha = "LRX9 \r0";
    int    k = $urandom_range(9);
    if (k == 0) begin
      int n = $urandom_range(1, 5);
      for (int i = 0; i < n; i++) s = $sformatf("%s%c", s, alpha[$urandom_range(alpha.len() - 1)]);
    end else begin
      int nd = (k == 1) ? 0 : $urandom_range(1, 6);
      if (k == 2) s = " ";
      s = $sformatf("%s%s", s, ($urandom_range(1) == 1) ? "R" : "L");
      for (int i = 0; i < nd; i++) s = $sformatf("%s%0d", s, $urandom_range(9));
      if (k == 3) s = {s, "\r"};
    end
    return {s, "\n"};
  endfunction

  // Drive one byte stream, randomly gapping input and stalling ready; hold forces the first stalls.
  task automatic run(input string s, input int stall_pct, input int gap_pct, input int hold);
    int idx = 0;
    int tail = 0;
    int guard = 0;
    int lim = 40 * s.len() + 200;
    logic [DW:0] e;
    model_feed(s);
    while (tail < 4 && guard < lim) begin
      @(negedge clk);
      guard++;
      bus.in_valid = (idx < s.len()) && ($urandom_range(99) >= gap_pct);
      bus.in_data  = (idx < s.len()) ? s[idx] : 8'h00;
      if (bus.valid && hold > 0) begin
        bus.ready = 1'b0;
        hold--;
      end else begin
        bus.ready = ($urandom_range(99) >= stall_pct);
      end
      if (bus.valid) begin
        check("in_ready_in_emit", 32'(bus.in_ready), 32'd0);
        if (!pending) check("valid_latency", 32'(cyc - lf_cyc), 32'd1);
        else          check("held_cmd", 32'({bus.direction, bus.distance}), 32'(held));
        held = {bus.direction, bus.distance};
        if (bus.ready) begin
          check("unexpected_valid", 32'(bus.valid), 32'(exp_q.size() != 0));
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("cmd_dir", 32'(bus.direction), 32'(e[DW]));
            check("cmd_dist", 32'(bus.distance), 32'(e[DW-1:0]));
            check("cmd_count_at_hs", 32'(bus.cmd_count), 32'(exp_count));
            exp_count = exp_count + 16'd1;
          end
        end
      end
      pending = bus.valid && !bus.ready;
      if (bus.in_valid && bus.in_ready) begin
        if (s[idx] == C_LF) lf_cyc = cyc;
        idx++;
      end
      if (idx >= s.len() && exp_q.size() == 0 && !bus.valid) tail++;
      else tail = 0;
    end
    bus.in_valid = 1'b0;
    check("pending_cmds", 32'(exp_q.size()), 32'd0);
    check("cmd_count_end", 32'(bus.cmd_count), 32'(exp_count));
    check("err", 32'(bus.err), 32'(exp_err));
    exp_q.delete();
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
    check({tag, "_valid"}, 32'(bus.valid), 32'd0);
    check({tag, "_direction"}, 32'(bus.direction), 32'd0);
    check({tag, "_distance"}, 32'(bus.distance), 32'd0);
    check({tag, "_cmd_count"}, 32'(bus.cmd_count), 32'd0);
    check({tag, "_err"}, 32'(bus.err), 32'd0);
  endtask

  initial begin
    string big;
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    bus.ready    = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_vals("reset");
    rst_n = 1'b1;

    run("L68\n", 0, 0, 0);
    run("R1000\r\nL5\n", 0, 0, 5);
    run("R70000\n", 0, 0, 0);
    run("R0\n", 0, 0, 0);
    run("R007\n", 0, 0, 0);
    run("X12\nL\nR3\n", 0, 0, 0);

    // partial line then asynchronous reset: nothing from it may appear
    run("L4", 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_vals("mid_reset");
    pend      = "";
    exp_count = '0;
    exp_err   = 1'b0;
    pending   = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    run("R9\n", 0, 0, 0);

    big = "";
    for (int i = 0; i < 300; i++) big = {big, rand_line()};
    run(big, 30, 20, 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/rotation_parser.md
# rotation_parser

Upstream front end of the dial pipeline. Takes the puzzle input as an ASCII byte stream, one rotation per line (`L68`, `R1000`, …), and converts each line into a `direction`/`distance` command. It presents that command to the dial-position stage over a valid/ready handshake. The block absorbs all text handling, so the dial stage only ever sees clean binary commands.

## Interface
- `DIST_W`, default 16: output distance width; the decimal accumulator saturates at 2^DIST_W−1.
- `CNT_W`, default 16: width of `cmd_count`.

Ports:
- `clk` in 1: single clock; all logic is on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: byte on `in_data` is valid.
- `in_data` in 8: ASCII byte.
- `in_ready` out 1: block accepts a byte this cycle.
- `valid` out 1: command available to the dial stage.
- `direction` out 1: 1 = `R`, 0 = `L`.
- `distance` out DIST_W: decoded decimal distance.
- `ready` in 1: dial stage accepts the command.
- `cmd_count` out CNT_W: number of commands handed off; wraps modulo 2^CNT_W.
- `err` out 1: sticky malformed-line flag (see Configuration).

## Operation
- A byte transfers when `in_valid && in_ready`. A command transfers when `valid && ready`.
- **IDLE**
  - `L`/`R` latches direction, clears the accumulator and digit flag, then goes to DIGITS.
  - LF (0x0A), CR (0x0D) and space (0x20) are consumed and ignored.
  - Any other byte is an error (see Configuration).
- **DIGITS**
  - `0`–`9`: acc ← acc×10 + digit, computed DIST_W+4 bits wide. If the result exceeds 2^DIST_W−1, acc sticks at 2^DIST_W−1 for the rest of the line. Sets the digit flag.
  - CR is ignored.
  - LF with the digit flag set goes to EMIT.
  - LF with no digits (`L\n`) is an error; nothing is emitted and the state returns to IDLE.
  - Any other byte is an error.
- **EMIT**
  - `valid`=1 with registered `direction`/`distance`; `in_ready`=0.
  - On `ready`: `cmd_count` increments and the state goes to IDLE.
- **SKIP** (only when error handling is compiled in)
  - Consumes bytes until LF, then goes to IDLE. No command is emitted.
- Leading zeros are legal: `R007` gives distance 7. Distance 0 is a legal command.
- `direction`/`distance` hold stable from `valid` rising until the handshake completes; they may change only in IDLE/DIGITS.

## Timing
- `in_ready` = (state != EMIT). It is registered-state-derived, with no combinational path from `ready`.
- LF accepted in cycle N gives `valid`=1 in cycle N+1.
- `ready` high in cycle N+1 means handshake in N+1, `in_ready`=1 in N+2.
- Sustained throughput is one byte per cycle, plus one EMIT cycle per line. This is acceptable because the dial stage is slower (2 cycles per command).
- `ready` low in EMIT: the block stalls indefinitely with outputs held.
- Reset values: `in_ready`=1, `valid`=0, `direction`=0, `distance`=0, `cmd_count`=0, `err`=0, state=IDLE, acc=0.
- Reset asserted mid-line or in EMIT discards the partial or pending command immediately (asynchronous). No command is emitted after release.

## Configuration
- `ROT_PARSER_ERR_EN` defined:
  - An unexpected byte, or a digitless line, sets `err`.
  - `err` stays set until reset.
  - The state goes to SKIP. If the offending byte was LF, the state goes to IDLE instead.
  - The offending line produces no command.
- `ROT_PARSER_ERR_EN` undefined:
  - Unexpected bytes are silently consumed and ignored in the current state.
  - Digitless lines are dropped.
  - SKIP state is not generated.
  - `err` is tied 0.

## Structure
- Shared package `rot_pkg`:
  - ASCII constants `ASCII_L`, `ASCII_R`, `ASCII_0`, `ASCII_9`, `ASCII_LF`, `ASCII_CR`, `ASCII_SP`.
  - State enum `parse_state_t` {IDLE, DIGITS, EMIT, SKIP}.
  - Default widths `DIST_W`/`CNT_W`, also used by the dial stage.
- One sub-module, `rot_dec_acc`:
  - Inputs: clear, digit-enable, 4-bit digit.
  - Outputs: DIST_W saturating decimal accumulator and digit-seen flag.
- The top-level FSM and output register live in `rotation_parser`.

## Test plan
- `"L68\n"` with `ready`=1: one command, `direction`=0, `distance`=68, `valid` one cycle after the LF is accepted, `cmd_count`=1.
- `"R1000\r\nL5\n"` with `ready` held 0 for 5 cycles after the first `valid`:
  - First command R/1000 is held stable and `in_ready`=0 throughout.
  - Then L/5 follows.
  - `cmd_count`=2.
- `"R70000\n"`: `distance`=65535 (saturated), `direction`=1. `"R0\n"`: `distance`=0, emitted.
- With `ROT_PARSER_ERR_EN`: `"X12\nL\nR3\n"` gives `err`=1 after X, no command for the first two lines, then exactly one command R/3.
- Without `ROT_PARSER_ERR_EN`: the same stream gives `err`=0; `R3` is emitted and `L\n` is dropped.
- Assert `rst_n`=0 after `"L4"`, then send `"R9\n"`: only R/9 is emitted, and all outputs read reset values during reset.
